clock_mode_ctrl: RTL
====================

# clock_mode_ctrl

Time-keeping and time-setting controller for the board's HH:MM digital clock. Divides pCLK down to a 1 Hz tick, owns the BCD hour/minute and binary second registers, and runs a mode state machine so two toggle-switch buttons can set the time. Drives the four 7-segment digit values (to the existing BCD-to-segment decoders) and a per-digit blank mask that blinks the field being edited.

## Interface
- TICK_DIV, 50_000_000, pCLK cycles per second tick (≥2)
- DEB_CYCLES, 500_000, consecutive stable cycles required to accept a button level change (≥2)
- BLINK_DIV, 25_000_000, pCLK cycles per blink half-period (≥2)
- pCLK  in  1  system clock
- nRST  in  1  reset, asynchronous, active-low
- btn_mode  in  1  raw mode button (TSW[0]), active high, asynchronous to pCLK
- btn_inc  in  1  raw increment button (TSW[1]), active high, asynchronous to pCLK
- hr_bcd  out  8  hours, two BCD digits, [7:4] tens, 00–23
- min_bcd  out  8  minutes, two BCD digits, [7:4] tens, 00–59
- sec  out  6  seconds, binary 0–59 (seconds LED bar)
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 unused
- blank  out  4  1 = blank digit; [3:2] hour digits, [1:0] minute digits
- sec_tick  out  1  one-cycle pulse per second, RUN only

## Operation
- Reset values: hr_bcd 8'h00, min_bcd 8'h00, sec 0, mode RUN, blank 4'b0000, sec_tick 0; all dividers, debouncers and blink phase cleared.
- Buttons: each passes a 2-flop synchronizer, then a debouncer; debounced level changes only after the synced value differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count. Debounced rising edge produces a one-cycle press pulse. Releases produce nothing.
- FSM: RUN –mode press→ SET_HR –mode press→ SET_MIN –mode press→ RUN. Encoding 11 is unreachable; if ever entered, next cycle goes to RUN.
- RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and sec_tick fires. On tick: sec+1; at 59 wraps to 0 and minutes +1; minutes 59 wrap to 00 and hours +1; hours 23 wrap to 00 (23:59:59 → 00:00:00). inc presses ignored.
- SET_HR: prescaler and sec frozen; inc press → hours +1 mod 24 (09→10, 23→00); minutes unaffected.
- SET_MIN: prescaler and sec frozen; inc press → minutes +1 mod 60, no carry into hours.
- Leaving SET_MIN to RUN: sec and prescaler cleared, so first sec_tick is exactly TICK_DIV cycles later.
- Blink: phase toggles every BLINK_DIV cycles, forced to 0 on every mode change (edited field visible immediately). SET_HR: blank = {phase,phase,0,0}; SET_MIN: {0,0,phase,phase}; RUN: 0000.
- Simultaneous mode and inc press in the same cycle: mode wins, inc discarded.
- nRST assertion mid-operation: immediate return to reset values regardless of state.

## Timing
- Button latency: mode/value registers update DEB_CYCLES+3 pCLK edges after the first edge sampling a clean raw rising level (2 sync, DEB_CYCLES debounce, 1 edge detect).
- sec_tick registered; sec/min/hr reflect the increment on the same edge sec_tick rises.
- blank registered, updated on the edge following a phase toggle or mode change.
- All outputs registered; no combinational input-to-output path.

## Configuration
- CLOCK_CTRL_AUTOREPEAT_EN defined: in SET_HR/SET_MIN, holding inc (debounced high) for 50·DEB_CYCLES cycles after its press pulse generates an additional press pulse, then one every 20·DEB_CYCLES cycles until release; release stops repeats immediately. Repeat counter clears on release and on mode change.
- Not defined: one increment per press only; repeat logic absent.

## Test plan
(Sim params TICK_DIV=10, DEB_CYCLES=4, BLINK_DIV=8.)
- Reset then 600 ticks of RUN → min_bcd 8'h10, hr_bcd 8'h00, sec 0; sec_tick exactly every 10 cycles.
- Preload via set modes 23:59, return to RUN, run 60 ticks → 00:00, sec 0.
- btn_inc glitch 3 cycles high then low → no change; clean hold ≥ DEB_CYCLES → exactly one increment after DEB_CYCLES+3 edges.
- Mode press ×1, inc ×5 → SET_HR, hr 8'h05, blank toggling 1100/0000 every 8 cycles starting visible; mode press → SET_MIN, blank 0011 pattern; inc ×61 → min 8'h01, hr still 8'h05.
- Mode and inc debounced on same cycle in SET_HR → mode 10, hr unchanged; nRST pulsed in SET_MIN → all outputs to reset values.
- With CLOCK_CTRL_AUTOREPEAT_EN, hold inc in SET_MIN 200+80·3 cycles past press → min incremented 1+1+3 = 5; without macro → 1.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: HH:MM:SS time-keeping and time-setting controller.
// Divides pCLK to a 1 Hz tick, keeps BCD hours/minutes and binary seconds,
// and lets two debounced buttons step through RUN / SET_HR / SET_MIN.
// Optional macro CLOCK_CTRL_AUTOREPEAT_EN: holding inc in a set mode
// auto-repeats increments (first after 50*DEB_CYCLES, then every 20*DEB_CYCLES).
module clock_mode_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic       pCLK,
  input  logic       nRST,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic [3:0] blank,
  output logic       sec_tick
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam int BLK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  // Index 0 is the mode button, index 1 the increment button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d, deb_prev_q;
  logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            press;
  logic                  mode_press, inc_press, set_mode, rep_pulse;

  state_t                state_q, state_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [5:0]            sec_q, sec_d;
  logic [7:0]            min_q, min_d, hr_q, hr_d;
  logic                  tick_q, tick_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  phase_q, phase_d;
  logic [3:0]            blank_q, blank_d;

  // Next BCD minute value, 59 wraps to 00.
  function automatic logic [7:0] min_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Next BCD hour value, 23 wraps to 00.
  function automatic logic [7:0] hr_inc(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
  end

  assign press      = deb_q & ~deb_prev_q;
  assign mode_press = press[0];
  assign set_mode   = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
  assign inc_press  = press[1] | rep_pulse;

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
  localparam int REP_FIRST = 50 * DEB_CYCLES;
  localparam int REP_NEXT  = 20 * DEB_CYCLES;
  localparam int REP_W     = $clog2(REP_FIRST + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
  logic             rep_first_q, rep_first_d;

  // Hold timer: zero means idle; it restarts on each real press and each repeat.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = rep_first_q;
    rep_pulse   = 1'b0;
    rep_limit   = rep_first_q ? REP_W'(REP_FIRST) : REP_W'(REP_NEXT);
    if (set_mode && deb_q[1] && !mode_press) begin
      if (press[1]) begin
        rep_cnt_d   = REP_W'(1);
        rep_first_d = 1'b1;
      end else if (rep_cnt_q != '0) begin
        if (rep_cnt_q == rep_limit) begin
          rep_pulse   = 1'b1;
          rep_cnt_d   = REP_W'(1);
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
    end
  end

  // Auto-repeat timer registers.
  always_ff @(posedge pCLK or negedge nRST) begin
    if (!nRST) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  // Mode FSM, prescaler, time counters and blink; mode press always beats inc.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    tick_d    = 1'b0;
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    blank_d   = 4'b0000;
    case (state_q)
      ST_RUN: begin
        if (pre_q == PRE_W'(TICK_DIV - 1)) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 8'h59) begin
              min_d = 8'h00;
              hr_d  = hr_inc(hr_q);
            end else begin
              min_d = min_inc(min_q);
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        if (mode_press) state_d = ST_SET_HR;
      end
      ST_SET_HR: begin
        if (mode_press) state_d = ST_SET_MIN;
        else if (inc_press) hr_d = hr_inc(hr_q);
      end
      ST_SET_MIN: begin
        if (mode_press) begin
          state_d = ST_RUN;
          sec_d   = 6'd0;
          pre_d   = '0;
        end else if (inc_press) begin
          min_d = min_inc(min_q);
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (state_d != state_q) begin
      blk_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    end
    case (state_q)
      ST_SET_HR:  blank_d = {phase_q, phase_q, 2'b00};
      ST_SET_MIN: blank_d = {2'b00, phase_q, phase_q};
      default:    blank_d = 4'b0000;
    endcase
  end

  // All state registers; asynchronous active-low reset.
  always_ff @(posedge pCLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
      state_q    <= ST_RUN;
      pre_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      tick_q     <= 1'b0;
      blk_cnt_q  <= '0;
      phase_q    <= 1'b0;
      blank_q    <= '0;
    end else begin
      sync1_q    <= {btn_inc, btn_mode};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      tick_q     <= tick_d;
      blk_cnt_q  <= blk_cnt_d;
      phase_q    <= phase_d;
      blank_q    <= blank_d;
    end
  end

  assign hr_bcd   = hr_q;
  assign min_bcd  = min_q;
  assign sec      = sec_q;
  assign mode     = state_q;
  assign blank    = blank_q;
  assign sec_tick = tick_q;

endmodule
